// File: rtl/tpu_isa_pkg.sv
// Shared ISA definitions for the instruction issue path: opcodes,
// issue-sequencer state encoding and execution-unit indices.
package tpu_isa_pkg;

  localparam int OP_BITS_DEF = 4;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LOAD_W = 4'd1;
  localparam logic [3:0] OP_LOAD_A = 4'd2;
  localparam logic [3:0] OP_EXEC   = 4'd3;
  localparam logic [3:0] OP_STORE  = 4'd4;
  localparam logic [3:0] OP_HALT   = 4'd5;

  localparam logic [1:0] UNIT_LOAD_W = 2'd0;
  localparam logic [1:0] UNIT_LOAD_A = 2'd1;
  localparam logic [1:0] UNIT_EXEC   = 2'd2;
  localparam logic [1:0] UNIT_STORE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } issue_state_e;

endpackage

// File: rtl/inst_issue_ctrl_edge_pulse.sv
// Rising-edge detector: one-cycle pulse on a 0->1 transition of i_sig.
module edge_pulse (
  input  logic clk,
  input  logic reset_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) r_prev <= 1'b0;
    else          r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/inst_issue_ctrl.sv
// Instruction issue sequencer: fetches words from the instruction buffer,
// decodes the opcode and dispatches to one of four execution units.
//
// state  | meaning
// IDLE   | out of reset, waiting for a start edge
// REQ    | one-cycle fetch request (flag) to the buffer
// WAIT   | waiting for init_inst_pulse plus FETCH_LAT cycles
// DECODE | capture opcode/payload, retire NOP/HALT or dispatch a unit
// EXEC   | waiting for the dispatched unit's done
// NEXT   | choose between next fetch and DONE
// DONE   | program finished; start edge re-runs
// ERROR  | illegal opcode seen; start edge re-runs
module inst_issue_ctrl
  import tpu_isa_pkg::*;
#(
  parameter int INST_BITS = 128,
  parameter int OP_BITS   = OP_BITS_DEF,
  parameter int FETCH_LAT = 0,
  parameter int CNT_BITS  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         ib_en,
  output logic                         flag,
  input  logic                         init_inst_pulse,
  input  logic                         complete_flag,
  input  logic [INST_BITS-1:0]         instruction,
  output logic [3:0]                   unit_start,
  input  logic [3:0]                   unit_done,
  output logic [INST_BITS-OP_BITS-1:0] op_payload,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [OP_BITS-1:0]           err_opcode,
  output logic [CNT_BITS-1:0]          retired
);

  localparam int PAY_BITS = INST_BITS - OP_BITS;
  localparam int LAT_W    = $clog2(FETCH_LAT + 2);

  issue_state_e r_state, w_state_nxt;

  logic                 w_start_rise;
  logic                 w_fetch_ready;
  logic                 w_retire;
  logic                 w_unit_hit;
  logic                 w_illegal;
  logic [1:0]           w_unit_sel;
  logic [OP_BITS-1:0]   w_opcode;
  logic [PAY_BITS-1:0]  w_payload;

  logic                 r_last_q;
  logic                 r_fetched;
  logic [LAT_W-1:0]     r_lat_cnt;
  logic [1:0]           r_unit;
  logic [PAY_BITS-1:0]  r_op_payload;
  logic [OP_BITS-1:0]   r_err_opcode;
  logic [CNT_BITS-1:0]  r_retired;

  edge_pulse u_start_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_sig   (start),
    .o_rise  (w_start_rise)
  );

  assign w_opcode  = instruction[INST_BITS-1 -: OP_BITS];
  assign w_payload = instruction[PAY_BITS-1:0];
  assign w_illegal = (w_opcode > OP_BITS'(OP_HALT));
  assign w_unit_hit = unit_done[r_unit];

  // The first pulse of a fetch is taken; later pulses in WAIT are ignored.
  assign w_fetch_ready = (FETCH_LAT == 0) ? (init_inst_pulse && !r_fetched)
                                          : (r_fetched && r_lat_cnt == LAT_W'(1));

  always_comb begin
    w_unit_sel = UNIT_LOAD_W;
    case (w_opcode)
      OP_BITS'(OP_LOAD_A): w_unit_sel = UNIT_LOAD_A;
      OP_BITS'(OP_EXEC):   w_unit_sel = UNIT_EXEC;
      OP_BITS'(OP_STORE):  w_unit_sel = UNIT_STORE;
      default:             w_unit_sel = UNIT_LOAD_W;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    flag        = 1'b0;
    unit_start  = 4'b0000;
    w_retire    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (w_start_rise) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        flag        = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_fetch_ready) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_opcode == OP_BITS'(OP_NOP)) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_NEXT;
        end else if (w_opcode == OP_BITS'(OP_HALT)) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_illegal) begin
          w_state_nxt = ST_ERROR;
        end else begin
          unit_start[w_unit_sel] = 1'b1;
          w_state_nxt            = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_unit_hit) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        w_state_nxt = r_last_q ? ST_DONE : ST_REQ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_q     <= 1'b0;
      r_fetched    <= 1'b0;
      r_lat_cnt    <= '0;
      r_unit       <= UNIT_LOAD_W;
      r_op_payload <= '0;
      r_err_opcode <= '0;
      r_retired    <= '0;
    end else begin
      if ((r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR) && w_start_rise) begin
        r_retired <= '0;
        r_last_q  <= 1'b0;
      end else if (w_retire && r_retired != '1) begin
        r_retired <= r_retired + CNT_BITS'(1);
      end

      if (r_state == ST_WAIT) begin
        if (init_inst_pulse && !r_fetched) begin
          r_fetched <= 1'b1;
          r_last_q  <= complete_flag;
          r_lat_cnt <= LAT_W'(FETCH_LAT);
        end else if (r_fetched && r_lat_cnt != '0) begin
          r_lat_cnt <= r_lat_cnt - LAT_W'(1);
        end
      end else begin
        r_fetched <= 1'b0;
      end

      if (r_state == ST_DECODE) begin
        r_op_payload <= w_payload;
        r_unit       <= w_unit_sel;
        if (w_illegal) r_err_opcode <= w_opcode;
      end
    end
  end

  assign busy       = !(r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);
  assign ib_en      = busy;
  assign done       = (r_state == ST_DONE);
  assign error      = (r_state == ST_ERROR);
  assign op_payload = r_op_payload;
  assign err_opcode = r_err_opcode;
  assign retired    = r_retired;

endmodule

// File: tb/tb_inst_issue_ctrl.sv
// Bench for inst_issue_ctrl: behavioural buffer and unit models, with a
// scoreboard of expected unit_start patterns per program.
module tb_inst_issue_ctrl;
  import tpu_isa_pkg::*;

  localparam int IB = 128;
  localparam int OB = 4;
  localparam int PB = IB - OB;
  localparam int CB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic          start0, iip0, cf0, start1, iip1, cf1;
  logic [IB-1:0] inst0, inst1;
  logic [3:0]    unit_done0, unit_done1, unit_start0, unit_start1;
  logic          ib_en0, flag0, busy0, done0, error0;
  logic          ib_en1, flag1, busy1, done1, error1;
  logic [PB-1:0] op_payload0, op_payload1;
  logic [OB-1:0] err_opcode0, err_opcode1;
  logic [CB-1:0] retired0, retired1;

  inst_issue_ctrl #(.INST_BITS(IB), .OP_BITS(OB), .FETCH_LAT(0), .CNT_BITS(CB)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .ib_en(ib_en0), .flag(flag0),
    .init_inst_pulse(iip0), .complete_flag(cf0), .instruction(inst0),
    .unit_start(unit_start0), .unit_done(unit_done0), .op_payload(op_payload0),
    .busy(busy0), .done(done0), .error(error0), .err_opcode(err_opcode0), .retired(retired0)
  );

  inst_issue_ctrl #(.INST_BITS(IB), .OP_BITS(OB), .FETCH_LAT(1), .CNT_BITS(CB)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .ib_en(ib_en1), .flag(flag1),
    .init_inst_pulse(iip1), .complete_flag(cf1), .instruction(inst1),
    .unit_start(unit_start1), .unit_done(unit_done1), .op_payload(op_payload1),
    .busy(busy1), .done(done1), .error(error1), .err_opcode(err_opcode1), .retired(retired1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [IB-1:0] mk(input logic [3:0] op, input logic [PB-1:0] pay);
    return {op, pay};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Buffer/unit model for the FETCH_LAT=0 instance.
  logic [IB-1:0] prog0 [0:7];
  logic [3:0]    exp_q0 [$];
  int  end_addr0 = 0, addr0 = 0, fetches0 = 0, flags0 = 0;
  int  done_dly = 1, cnt0 = 0, unit0 = 0;
  bit  proc0 = 0, pend0 = 0, flag_prev0 = 0, spur_en = 0;

  initial begin : model0
    iip0 = 0; cf0 = 0; inst0 = '0; unit_done0 = '0;
    forever begin
      tick(1);
      iip0 = 0;
      if (pend0) begin
        iip0 = 1;
        inst0 = prog0[addr0];
        cf0 = proc0 && (addr0 == end_addr0);
        addr0++;
        fetches0++;
        pend0 = 0;
      end
      if (flag0) begin
        chk("flag_low_gap", flag_prev0, 0);
        flags0++;
        pend0 = 1;
      end
      flag_prev0 = flag0;
      unit_done0 = '0;
      if (cnt0 > 0) begin
        cnt0--;
        if (cnt0 == 0) unit_done0[unit0] = 1'b1;
        else if (spur_en && (cnt0 % 5 == 0)) unit_done0[0] = 1'b1;
      end
      if (unit_start0 != 4'b0) begin
        if (exp_q0.size() == 0) chk("unexpected_start0", unit_start0, 4'b0);
        else chk("unit_start0", unit_start0, exp_q0.pop_front());
        for (int i = 0; i < 4; i++) if (unit_start0[i]) unit0 = i;
        cnt0 = done_dly;
      end
    end
  end

  // Model for the FETCH_LAT=1 instance: junk word with the pulse, real word a cycle later.
  logic [IB-1:0] prog1 [0:3];
  logic [3:0]    exp_q1 [$];
  int  addr1 = 0, flags1 = 0, stage1 = 0;
  logic [3:0] pend_u1 = '0;

  initial begin : model1
    iip1 = 0; cf1 = 0; inst1 = '0; unit_done1 = '0;
    forever begin
      tick(1);
      iip1 = 0;
      if (stage1 == 1) begin
        iip1 = 1;
        inst1 = mk(4'hB, '0);
        stage1 = 2;
      end else if (stage1 == 2) begin
        inst1 = prog1[addr1];
        addr1++;
        stage1 = 0;
      end
      if (flag1) begin
        flags1++;
        stage1 = 1;
      end
      unit_done1 = pend_u1;
      pend_u1 = '0;
      if (unit_start1 != 4'b0) begin
        if (exp_q1.size() == 0) chk("unexpected_start1", unit_start1, 4'b0);
        else chk("unit_start1", unit_start1, exp_q1.pop_front());
        pend_u1 = unit_start1;
      end
    end
  end

  task automatic pulse_start0();
    start0 = 1;
    tick(2);
    start0 = 0;
  endtask

  task automatic wait_end(input bit which, input int max);
    int k = 0;
    while (!(which ? (done1 || error1) : (done0 || error0)) && k < max) begin
      tick(1);
      k++;
    end
    chk(which ? "end_timeout1" : "end_timeout0",
        which ? (done1 || error1) : (done0 || error0), 1);
  endtask

  task automatic wait_unit_start0(input int max);
    int k = 0;
    while (unit_start0 == 4'b0 && k < max) begin
      tick(1);
      k++;
    end
    chk("start_timeout0", unit_start0 != 4'b0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ib_en"}, ib_en0, 0);
    chk({tag, "_flag"}, flag0, 0);
    chk({tag, "_unit_start"}, unit_start0, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_error"}, error0, 0);
    chk({tag, "_op_payload"}, op_payload0, 0);
    chk({tag, "_err_opcode"}, err_opcode0, 0);
    chk({tag, "_retired"}, retired0, 0);
  endtask

  task automatic new_prog0();
    addr0 = 0; fetches0 = 0; flags0 = 0;
    for (int i = 0; i < 8; i++) prog0[i] = mk(OP_NOP, '0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    reset_n = 0; start0 = 0; start1 = 0;
    tick(3);
    chk_reset_outputs("reset");
    reset_n = 1;
    tick(1);

    // NOP, LOAD_W, EXEC, HALT
    new_prog0();
    prog0[0] = mk(OP_NOP, 'h0);
    prog0[1] = mk(OP_LOAD_W, 'h11);
    prog0[2] = mk(OP_EXEC, 'h22);
    prog0[3] = mk(OP_HALT, 'h55);
    proc0 = 0; done_dly = 1;
    exp_q0.push_back(4'b0001);
    exp_q0.push_back(4'b0100);
    pulse_start0();
    wait_end(0, 200);
    chk("t1_done", done0, 1);
    chk("t1_error", error0, 0);
    chk("t1_retired", retired0, 4);
    chk("t1_ib_en", ib_en0, 0);
    chk("t1_busy", busy0, 0);
    chk("t1_flags", flags0, 4);
    chk("t1_queue", exp_q0.size(), 0);
    chk("t1_payload", op_payload0, 'h55);

    // Procedural buffer, end_addr = 2, no HALT
    new_prog0();
    prog0[0] = mk(OP_LOAD_A, 'h1);
    prog0[1] = mk(OP_STORE, 'h2);
    prog0[2] = mk(OP_STORE, 'h3);
    prog0[3] = mk(OP_LOAD_W, 'h4);
    proc0 = 1; end_addr0 = 2;
    exp_q0.push_back(4'b0010);
    exp_q0.push_back(4'b1000);
    exp_q0.push_back(4'b1000);
    pulse_start0();
    wait_end(0, 300);
    chk("t2_done", done0, 1);
    chk("t2_retired", retired0, 3);
    chk("t2_fetches", fetches0, 3);
    chk("t2_complete", cf0, 1);
    chk("t2_queue", exp_q0.size(), 0);

    // Illegal opcode at address 1
    new_prog0();
    prog0[0] = mk(OP_NOP, 'h0);
    prog0[1] = mk(4'hA, 'h7);
    prog0[2] = mk(OP_LOAD_W, 'h8);
    proc0 = 0;
    pulse_start0();
    wait_end(0, 200);
    chk("t3_error", error0, 1);
    chk("t3_done", done0, 0);
    chk("t3_err_opcode", err_opcode0, 4'hA);
    chk("t3_retired", retired0, 1);
    chk("t3_ib_en", ib_en0, 0);
    tick(10);
    chk("t3_busy_after", busy0, 0);
    chk("t3_queue", exp_q0.size(), 0);

    // Slow EXEC with spurious unit_done[0]
    new_prog0();
    prog0[0] = mk(OP_EXEC, 'h1234);
    prog0[1] = mk(OP_HALT, 'h0);
    done_dly = 50; spur_en = 1;
    exp_q0.push_back(4'b0100);
    pulse_start0();
    wait_unit_start0(50);
    tick(1);
    for (int i = 0; i < 45; i++) begin
      chk("t4_payload_hold", op_payload0, 'h1234);
      chk("t4_no_fetch", {busy0, flag0}, 2'b10);
      tick(1);
    end
    wait_end(0, 100);
    chk("t4_done", done0, 1);
    chk("t4_retired", retired0, 2);
    spur_en = 0; done_dly = 1;

    // Reset during EXEC, then a fresh run
    new_prog0();
    prog0[0] = mk(OP_LOAD_W, 'h9);
    prog0[1] = mk(OP_HALT, 'h0);
    done_dly = 1000;
    exp_q0.push_back(4'b0001);
    pulse_start0();
    wait_unit_start0(50);
    tick(3);
    reset_n = 0;
    cnt0 = 0;
    tick(1);
    chk_reset_outputs("t5_reset");
    reset_n = 1;
    done_dly = 1;
    tick(5);
    chk("t5_idle_busy", busy0, 0);
    new_prog0();
    prog0[0] = mk(OP_NOP, 'h0);
    prog0[1] = mk(OP_HALT, 'h0);
    pulse_start0();
    wait_end(0, 200);
    chk("t5_done", done0, 1);
    chk("t5_retired", retired0, 2);
    chk("t5_queue", exp_q0.size(), 0);

    // FETCH_LAT=1 instance, start held high across DONE
    prog1[0] = mk(OP_LOAD_A, 'h3);
    prog1[1] = mk(OP_HALT, 'h0);
    addr1 = 0; flags1 = 0;
    exp_q1.push_back(4'b0010);
    start1 = 1;
    tick(2);
    wait_end(1, 200);
    chk("t6_done", done1, 1);
    chk("t6_error", error1, 0);
    chk("t6_retired", retired1, 2);
    tick(20);
    chk("t6_held_busy", busy1, 0);
    chk("t6_held_done", done1, 1);
    chk("t6_held_flags", flags1, 2);
    start1 = 0;
    tick(2);
    addr1 = 0;
    exp_q1.push_back(4'b0010);
    start1 = 1;
    tick(2);
    chk("t6_rerun_busy", busy1, 1);
    wait_end(1, 200);
    chk("t6_rerun_done", done1, 1);
    chk("t6_rerun_retired", retired1, 2);
    chk("t6_rerun_flags", flags1, 4);
    chk("t6_queue", exp_q1.size(), 0);
    start1 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
